// File: rtl/apb_master_arbiter_pkg.sv
// apb_arb_pkg: shared FSM state type and defaults for apb_master_arbiter.
// Provides width/requester/timeout defaults and the round-robin step helper.
package apb_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_if: APB bus signal set between one master and the completer fabric.
// master: drives paddr/psel/penable/pwrite/pwdata; slave: drives pready/prdata/pslverr.
interface apb_if
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin pick starting at ptr_i.
// In: req_i vector, ptr_i; out: one-hot gnt_o, binary idx_o, valid_o (any grant).
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NREQ = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] j;
    logic             found;

    // Walk ptr, ptr+1, ... modulo NUM_REQ; first asserted request wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            j = pos[IDX_W-1:0];
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbitrated APB master for NUM_REQ requesters.
// Ports: pclk/presetn; req_valid/req_ready/req_addr/req_write/req_wdata command side;
// rsp_valid/rsp_rdata/rsp_slverr response side; apb (apb_if.master) bus side.
// Optional macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase stall timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    apb_if.master                         apb
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("apb_master_arbiter: parameter out of range");
    end

    arb_state_e state_q, state_d;

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Gated by presetn so req_ready reads 0 while reset is held.
    assign req_ready = (presetn && state_q == IDLE) ? arb_gnt : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_idx_d    = gnt_idx_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d   = SETUP;
                    gnt_idx_d = arb_idx;
                    rr_ptr_d  = IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
                    addr_d    = addr_arr[arb_idx];
                    write_d   = req_write[arb_idx];
                    wdata_d   = wdata_arr[arb_idx];
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ACCESS: begin
                if (apb.pready) begin
                    state_d                = IDLE;
                    rsp_valid_d[gnt_idx_q] = 1'b1;
                    rsp_rdata_d            = write_q ? '0 : apb.prdata;
                    rsp_slverr_d           = apb.pslverr;
                end
`ifdef APB_ARB_TIMEOUT_EN
                // Limit reached with no pready: abandon and report error.
                else if (tmo_q == TMO_MAX) begin
                    state_d                = IDLE;
                    rsp_valid_d[gnt_idx_q] = 1'b1;
                    rsp_rdata_d            = '0;
                    rsp_slverr_d           = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // APB strobes registered from the next state.
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_idx_q    <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign apb.paddr   = addr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = write_q;
    assign apb.pwdata  = wdata_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Arbitrated APB master bridging up to NUM_REQ independent requesters onto one APB bus via the team's `apb_if` master signal set. Grants requests round-robin, sequences the APB SETUP/ACCESS protocol and returns each response to the requester that issued it. Sits between internal command sources (register sequencers, DMA descriptor fetch, debug port) and the APB peripheral fabric.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 32: APB address width.
- DATA_WIDTH, 32: APB data width.
- TIMEOUT_CYCLES, 256: ACCESS-phase stall limit. Used only with APB_ARB_TIMEOUT_EN.
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept; one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid with rsp_valid.
- rsp_slverr  out  1  error flag, shared; valid with rsp_valid.
- paddr, psel, penable, pwrite, pwdata  out  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB master outputs.
- pready, prdata, pslverr  in  1/DATA_WIDTH/1  APB completer inputs.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- IDLE: if any req_valid is high, the round-robin arbiter selects g. req_ready[g] is asserted combinationally in the same cycle. addr/write/wdata of g are captured into registers, and the FSM moves to SETUP. With no valid request, the FSM stays in IDLE.
- Round-robin: priority starts at rr_ptr and increases modulo NUM_REQ. After a grant to g, rr_ptr becomes (g+1) mod NUM_REQ. rr_ptr resets to 0.
- SETUP: psel=1, penable=0, with paddr/pwrite/pwdata from the captured command. Always exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata are held stable. The FSM stays in ACCESS while pready=0.
- On pready=1 in ACCESS:
  - Next cycle: rsp_valid[g]=1 for one cycle.
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_slverr = pslverr.
  - The FSM returns to IDLE.
- IDLE drives psel=0 and penable=0. paddr/pwrite/pwdata hold their last values.
- Requesters hold valid and fields stable until ready. The block never de-asserts req_ready without accepting.
- A requester may re-request in the same cycle its rsp_valid pulses; it is arbitrated normally.
- Only one transfer is outstanding at a time.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0; internal rr_ptr=0, grant index 0.
- Zero-wait transfer: handshake in cycle T (IDLE), SETUP in T+1, ACCESS with pready in T+2, rsp_valid and next possible handshake in T+3. Minimum 3 cycles per transfer.
- Each cycle of pready=0 in ACCESS adds one cycle.
- req_ready is combinational from req_valid and state. All APB outputs and all rsp_* outputs are registered.
- Reset asserted mid-transfer: all outputs go to reset values immediately and asynchronously. The transfer is abandoned, no rsp_valid is produced, and the FSM is in IDLE after release.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is terminated: psel and penable drop next cycle, the FSM enters IDLE, and rsp_valid[g] pulses with rsp_slverr=1 and rsp_rdata=0.
  - pready arriving in the same cycle as the limit wins; the response is normal.
- APB_ARB_TIMEOUT_EN undefined: no counter exists, and ACCESS waits for pready indefinitely.

## Structure
- Package apb_arb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS);
  - default width constants;
  - the TIMEOUT_CYCLES default.
- Sub-module apb_rr_arbiter: NUM_REQ request vector plus rr_ptr in, one-hot grant and index out. Purely combinational. The pointer register lives in the parent.

## Test plan
- Single read: requester 0 reads 0x10, completer returns prdata=0xDEADBEEF with pready at the first ACCESS → psel high 2 cycles, rsp_valid[0] at T+3, rsp_rdata=0xDEADBEEF, rsp_slverr=0.
- Round-robin: all 4 requesters valid continuously, rr_ptr=0 → grant order 0,1,2,3,0, one grant every 3 cycles.
- Wait states plus error: write 0x55 to 0x20 with pready low 3 ACCESS cycles and pslverr=1 → paddr/pwdata stable 5 cycles, rsp_rdata=0, rsp_slverr=1.
- Reset in ACCESS: presetn low while penable=1 → psel/penable 0 immediately, no rsp_valid; after release a new request on requester 2 is served normally.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): pready held low → after 8 stalled cycles psel drops, rsp_valid pulses with rsp_slverr=1 and rsp_rdata=0.
